fetch_unit: RTL and testbench

- Instruction-fetch stage of the RV32I core.
- Sits directly upstream of the control/decode logic and supplies it with 32-bit instructions and their PCs.
- Owns the PC register and drives a request/response instruction-memory port.
- Buffers fetched words in a small FIFO; on a taken branch (PCsrc) it flushes the buffer and redirects.

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I instruction-fetch stage with PC register, single-outstanding
//            request/response memory port and a small instruction FIFO.
//            Optional FETCH_MISALIGN_CHK_EN adds a sticky misaligned-target flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                 A_WIDTH  = 32,
  parameter int                 D_WIDTH  = 32,
  parameter int                 DEPTH    = 2,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCsrc,
  input  logic [A_WIDTH-1:0] branch_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] instr_pc,
  output logic               misalign_err
);

  localparam int                 c_ptr_w    = $clog2(DEPTH);
  localparam int                 c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [A_WIDTH-1:0] c_four     = A_WIDTH'(4);
  localparam logic [A_WIDTH-1:0] c_low_mask = A_WIDTH'(3);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [A_WIDTH-1:0]   r_fetch_pc;
  logic [A_WIDTH-1:0]   r_req_pc;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [A_WIDTH-1:0]   r_mem_pc    [DEPTH];
  logic [D_WIDTH-1:0]   r_mem_instr [DEPTH];

  logic                 w_req_valid;
  logic                 w_req_fire;
  logic                 w_push;
  logic                 w_pop;
  logic [A_WIDTH-1:0]   w_target;

  assign w_target   = branch_target & ~c_low_mask;
  assign w_req_fire = w_req_valid & imem_req_ready;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_valid  = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_RUN: begin
        // Only RUN has nothing in flight, so count alone bounds occupancy.
        w_req_valid = !rst && !PCsrc && (r_count < c_depth);
        if (w_req_valid && imem_req_ready) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_push       = !PCsrc;
          w_next_state = S_RUN;
        end else if (PCsrc) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A response here always belongs to the stale request, even on a new redirect.
        if (imem_rsp_valid) begin
          w_next_state = S_RUN;
        end
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  assign w_pop = instr_valid && instr_ready && !PCsrc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_req_fire) begin
        r_req_pc <= r_fetch_pc;
      end
      if (PCsrc) begin
        r_fetch_pc <= w_target;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_req_pc + c_four;
          r_wr_ptr   <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_req_pc;
      r_mem_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_fetch_pc;
  assign instr_valid    = (r_count != '0);
  assign instr          = instr_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign instr_pc       = instr_valid ? r_mem_pc[r_rd_ptr]    : '0;

  // ---------------------------------------------------------------------------
  // Misaligned-target flag
  // ---------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (PCsrc && (branch_target[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed plus randomized bench for fetch_unit against a queue-based
//            reference model and a variable-latency instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCsrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  fetch_unit #(
    .A_WIDTH  (32),
    .D_WIDTH  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PCsrc          (PCsrc),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch stage
  logic [31:0] m_pc;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_err;
  ent_t        m_q[$];

  // Memory environment
  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat;
  bit          rand_lat;
  logic [31:0] mem_addr;

  int n_checks = 0;
  int n_pass   = 0;

  bit exp_mis;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic do_reset(input bit keep_mem);
    rst = 1'b1;
    PCsrc = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pc = 32'h0;
    m_out = 1'b0;
    m_stale = 1'b0;
    m_err = 1'b0;
    m_q.delete();
    if (!keep_mem) mem_busy = 1'b0;
  endtask

  // One clock: drive at posedge+1, check at posedge+5, advance model after edge.
  task automatic cyc(input bit pcs, input logic [31:0] tgt, input bit rdy, input bit rq);
    bit          rsp;
    bit          exp_req;
    bit          exp_iv;
    bit          dut_hs;
    logic [31:0] dut_addr;
    logic [31:0] rdata;
    ent_t        e;
    PCsrc = pcs;
    branch_target = tgt;
    instr_ready = rdy;
    imem_req_ready = rq;
    rsp = mem_busy && (mem_cnt == 0);
    rdata = rsp ? word_at(mem_addr) : $urandom();
    imem_rsp_valid = rsp;
    imem_rsp_data = rdata;
    #4;
    exp_req = !m_out && (m_q.size() < DEPTH) && !pcs;
    exp_iv  = (m_q.size() != 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("instr", instr, m_q[0].ins);
      check("instr_pc", instr_pc, m_q[0].pc);
    end
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    dut_hs = imem_req_valid && imem_req_ready;
    dut_addr = imem_addr;
    @(posedge clk);
    #1;
    if (pcs) begin
      if (m_out && rsp) begin
        m_out = 1'b0;
        m_stale = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
      m_q.delete();
      m_pc = tgt & ~32'd3;
`ifdef FETCH_MISALIGN_CHK_EN
      if (tgt[1:0] != 2'b00) m_err = 1'b1;
`endif
    end else begin
      if (exp_iv && rdy) void'(m_q.pop_front());
      if (m_out && rsp) begin
        if (!m_stale) begin
          e.pc = m_out_pc;
          e.ins = rdata;
          m_q.push_back(e);
          m_pc = m_out_pc + 32'd4;
        end
        m_out = 1'b0;
        m_stale = 1'b0;
      end else if (exp_req && rq) begin
        m_out = 1'b1;
        m_out_pc = m_pc;
      end
    end
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (dut_hs) begin
      mem_busy = 1'b1;
      mem_addr = dut_addr;
      mem_cnt = rand_lat ? int'($urandom_range(0, 2)) : (mem_lat - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [31:0] tgt;
    mem_busy = 1'b0;
    mem_cnt = 0;
    mem_lat = 1;
    rand_lat = 1'b0;
    mem_addr = '0;
`ifdef FETCH_MISALIGN_CHK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif

    // Reset values and first fetch with a 1-cycle memory
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    cyc(0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1);
    check("first_instr_valid", 32'(instr_valid), 32'd1);
    check("first_instr", instr, 32'h00500093);
    check("first_instr_pc", instr_pc, 32'h0);
    check("second_req_addr", imem_addr, 32'h4);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1'b1, 1'b1);

    // Backpressure: FIFO fills after two requests, one pop lets 0x8 go out
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1'b0, 1'b1);
    check("full_no_req", 32'(imem_req_valid), 32'd0);
    mem_lat = 3;
    cyc(0, 0, 1'b1, 1'b1);
    k = 0;
    while (!(m_out && m_out_pc == 32'h8) && k < 20) begin
      cyc(0, 0, 1'b0, 1'b1);
      k++;
    end
    if (k == 20) timeout("wait_req_8");

    // Redirect while 0x8 outstanding: response dropped, refetch at 0x40
    cyc(1, 32'h40, 1'b0, 1'b1);
    k = 0;
    while (m_q.size() == 0 && k < 20) begin
      cyc(0, 0, 1'b0, 1'b1);
      k++;
    end
    if (k == 20) timeout("wait_redirect_fill");
    check("redirect_instr_pc", instr_pc, 32'h40);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1'b1, 1'b1);

    // Redirect coincident with the response in WAIT
    mem_lat = 1;
    k = 0;
    while (!(m_out && !m_stale) && k < 20) begin
      cyc(0, 0, 1'b1, 1'b1);
      k++;
    end
    if (k == 20) timeout("wait_outstanding");
    cyc(1, 32'h40, 1'b1, 1'b1);
    PCsrc = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("coincide_req_valid", 32'(imem_req_valid), 32'd1);
    check("coincide_req_addr", imem_addr, 32'h40);
    check("coincide_no_push", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1'b1, 1'b1);

    // PC wrap at the top of the address space
    k = 0;
    while (m_out && k < 20) begin
      cyc(0, 0, 1'b1, 1'b0);
      k++;
    end
    if (k == 20) timeout("wait_idle_wrap");
    cyc(1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1);
    PCsrc = 1'b0;
    #1;
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_req_addr", imem_addr, 32'h0);
    check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1'b1, 1'b1);

    // Misaligned redirect target
    k = 0;
    while (m_out && k < 20) begin
      cyc(0, 0, 1'b1, 1'b0);
      k++;
    end
    if (k == 20) timeout("wait_idle_mis");
    cyc(1, 32'h42, 1'b1, 1'b1);
    check("mis_flag", 32'(misalign_err), 32'(exp_mis));
    PCsrc = 1'b0;
    #1;
    check("mis_req_addr", imem_addr, 32'h40);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1'b1, 1'b1);
    check("mis_sticky", 32'(misalign_err), 32'(exp_mis));

    // Reset in the middle of a transaction; late response must be ignored
    mem_lat = 3;
    k = 0;
    while (!m_out && k < 20) begin
      cyc(0, 0, 1'b1, 1'b1);
      k++;
    end
    if (k == 20) timeout("wait_out_reset");
    do_reset(1'b1);
    k = 0;
    while (mem_busy && k < 10) begin
      cyc(0, 0, 1'b1, 1'b0);
      k++;
    end
    if (k == 10) timeout("wait_stale_rsp");
    check("post_reset_empty", 32'(instr_valid), 32'd0);

    // Randomized traffic with variable memory latency
    rand_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tgt = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      cyc(($urandom_range(0, 19) == 0), tgt,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
